// File: rtl/clock_enable_gen.sv
// ---------------------------------------------------------------------------
// clock_enable_gen
// Generates NUM_CH single-cycle enable pulses that share one programmable
// period (div_active) and each sit at their own phase offset in that period.
// Supports start/stop, period reload at wrap, resync and sticky config error.
//
// Ports
//   clk         in   system clock
//   rst         in   synchronous active-high reset
//   run         in   1 = generate enables, 0 = stop and clear counter
//   div_in      in   new period in clk cycles (0 treated as 1)
//   div_load    in   strobe: capture div_in into the pending register
//   phase_in    in   per-channel phase, ch k = [k*CNT_WIDTH +: CNT_WIDTH]
//   resync      in   strobe: restart the period (counter -> 0)
//   err_clr     in   clears cfg_err
//   clk_enable  out  per-channel single-cycle enable pulses
//   wrap        out  pulse marking the last cycle of each period
//   cfg_err     out  sticky: some phase >= active period while running
//   div_active  out  period currently in use
// ---------------------------------------------------------------------------
module clock_enable_gen #(
    parameter int unsigned CNT_WIDTH   = 8,
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned DEFAULT_DIV = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          run,
    input  logic [CNT_WIDTH-1:0]          div_in,
    input  logic                          div_load,
    input  logic [NUM_CH*CNT_WIDTH-1:0]   phase_in,
    input  logic                          resync,
    input  logic                          err_clr,
    output logic [NUM_CH-1:0]             clk_enable,
    output logic                          wrap,
    output logic                          cfg_err,
    output logic [CNT_WIDTH-1:0]          div_active
);

    localparam int unsigned PHASE_W = NUM_CH * CNT_WIDTH;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0]   div_active_q, div_active_d;
    logic [CNT_WIDTH-1:0]   div_pend_q, div_pend_d;
    logic                   pend_q, pend_d;
    logic [NUM_CH-1:0]      en_q, en_d;
    logic                   wrap_q, wrap_d;
    logic                   cfg_err_q, cfg_err_d;

    logic [NUM_CH-1:0]      hit_c;
    logic [NUM_CH-1:0]      bad_c;
    logic                   at_wrap_c;
    logic                   run_now_c;
    logic                   restart_c;
    logic [PHASE_W-1:0]     phase_c;

    assign phase_c = phase_in;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (run)  state_d = S_RUN;
            S_RUN:   if (!run) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Per-channel phase match and phase-out-of-range detection
    always_comb begin
        hit_c = '0;
        bad_c = '0;
        for (int k = 0; k < int'(NUM_CH); k++) begin
            hit_c[k] = (cnt_q == phase_c[k*CNT_WIDTH +: CNT_WIDTH]);
            bad_c[k] = (phase_c[k*CNT_WIDTH +: CNT_WIDTH] >= div_active_q);
        end
    end

    assign at_wrap_c = (cnt_q == (div_active_q - CNT_WIDTH'(1)));
    assign run_now_c = (state_q == S_RUN) && run;
    // Period boundary where a pending div may be applied (wrap or resync)
    assign restart_c = run_now_c && (resync || at_wrap_c);

    // Output / datapath next-value logic
    always_comb begin
        cnt_d        = cnt_q;
        en_d         = '0;
        wrap_d       = 1'b0;
        div_active_d = div_active_q;
        div_pend_d   = div_pend_q;
        pend_d       = pend_q;
        cfg_err_d    = cfg_err_q;

        // Old pending value is applied first; a load on the same edge
        // re-arms pend so it only lands at the next boundary.
        if (pend_q && ((state_q == S_IDLE) || restart_c)) begin
            div_active_d = div_pend_q;
            pend_d       = 1'b0;
        end
        if (div_load) begin
            div_pend_d = (div_in == '0) ? CNT_WIDTH'(1) : div_in;
            pend_d     = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
            end
            S_RUN: begin
                if (!run) begin
                    cnt_d = '0;
                end else begin
                    en_d   = hit_c;
                    wrap_d = at_wrap_c;
                    cnt_d  = (resync || at_wrap_c) ? '0 : cnt_q + CNT_WIDTH'(1);
                end
            end
            default: begin
                cnt_d = '0;
            end
        endcase

        // Set wins over clear
        if (run_now_c && (|bad_c)) begin
            cfg_err_d = 1'b1;
        end else if (err_clr) begin
            cfg_err_d = 1'b0;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            div_active_q <= CNT_WIDTH'(DEFAULT_DIV);
            div_pend_q   <= CNT_WIDTH'(DEFAULT_DIV);
            pend_q       <= 1'b0;
            en_q         <= '0;
            wrap_q       <= 1'b0;
            cfg_err_q    <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            div_active_q <= div_active_d;
            div_pend_q   <= div_pend_d;
            pend_q       <= pend_d;
            en_q         <= en_d;
            wrap_q       <= wrap_d;
            cfg_err_q    <= cfg_err_d;
        end
    end

    assign clk_enable = en_q;
    assign wrap       = wrap_q;
    assign cfg_err    = cfg_err_q;
    assign div_active = div_active_q;

endmodule
